// File: rtl/bcd_to_binary13.sv
// rtl/bcd_to_binary13.sv - digit-serial BCD to 13-bit binary converter
//
// Purpose:
//   Takes BCD digits most-significant first over a valid/ready handshake.
//   Each accepted digit updates the result as Value = Value*10 + Digit,
//   saturating at 2^WIDTH-1. The conversion ends on DigitLast or after
//   NUM_DIGITS legal digits, and Done pulses for one cycle.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   synchronous active-low reset
//   Start      in   begin / restart a conversion, clears accumulator and flags
//   Digit      in   BCD digit, MSD first
//   DigitValid in   Digit is presented
//   DigitLast  in   Digit is the final one of this conversion
//   DigitReady out  Digit is consumed this cycle when DigitValid is high
//   Busy       out  conversion in progress
//   Done       out  one-cycle pulse, Value is final
//   Value      out  running / final binary result
//   Overflow   out  sticky, result saturated
//   Error      out  sticky, a non-BCD digit was consumed

module bcd_to_binary13 #(
    parameter int NUM_DIGITS = 4,
    parameter int WIDTH      = 13
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [3:0]       Digit,
    input  logic             DigitValid,
    input  logic             DigitLast,
    output logic             DigitReady,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Value,
    output logic             Overflow,
    output logic             Error
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    // Value*10 + 9 fits in WIDTH+4 bits, so the sum never wraps before
    // the saturation compare.
    localparam int SW = WIDTH + 4;

    localparam logic [SW-1:0]    SAT_EXT  = {{4{1'b0}}, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] SAT      = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_error;
    logic             r_busy;
    logic             r_done;

    logic [SW-1:0]    w_value_ext;
    logic [SW-1:0]    w_sum;
    logic             w_legal;
    logic             w_ready;
    logic             w_xfer;
    logic             w_end;

    assign w_value_ext = {{4{1'b0}}, r_value};
    assign w_sum       = (w_value_ext << 3) + (w_value_ext << 1)
                       + {{(SW-4){1'b0}}, Digit};
    assign w_legal     = (Digit <= 4'd9);

    // A concurrent Start wins over the digit, so the digit is refused.
    assign w_ready     = (r_state == S_ACCEPT) && !Start;
    assign w_xfer      = DigitValid && w_ready;

    // Illegal digits never advance the count, so only a legal digit can
    // complete the digit budget.
    assign w_end       = DigitLast || (w_legal && (r_count == LAST_CNT));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_value    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_state    <= S_ACCEPT;
                        r_busy     <= 1'b1;
                        r_value    <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end

                S_ACCEPT: begin
                    if (Start) begin
                        r_value    <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_error    <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_legal) begin
                            r_count <= r_count + CW'(1);
                            // Once saturated the result stays pinned.
                            if (r_overflow || (w_sum > SAT_EXT)) begin
                                r_value    <= SAT;
                                r_overflow <= 1'b1;
                            end else begin
                                r_value <= w_sum[WIDTH-1:0];
                            end
                        end else begin
                            r_error <= 1'b1;
                        end
                        if (w_end) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_state    <= S_ACCEPT;
                        r_busy     <= 1'b1;
                        r_value    <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_error    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign DigitReady = w_ready;
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign Value      = r_value;
    assign Overflow   = r_overflow;
    assign Error      = r_error;

endmodule

// File: doc/bcd_to_binary13.md
Name: bcd_to_binary13

Overview:
- Digit-serial decimal-to-binary converter; inverse of the existing quotient/remainder digit-extraction path.
- Accepts BCD digits most-significant first over a valid/ready handshake.
- Accumulates Value = Value*10 + Digit into a 13-bit result (0..8191).
- Used to load operator-entered or stored decimal thresholds and reaction-time limits into the binary datapath.

Parameters:
- NUM_DIGITS, 4, maximum digits per conversion; conversion ends automatically after this many legal digits.
- WIDTH, 13, result width; saturation limit is 2^WIDTH-1 (8191).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset_n  input  1  synchronous, active-low reset. Sampled on the rising edge of Clk.
- Start  input  1  one-cycle request to begin a new conversion; clears the accumulator.
- Digit  input  4  BCD digit, MSD first.
- DigitValid  input  1  Digit is presented.
- DigitLast  input  1  qualifies Digit as the final digit (early finish); meaningful only with DigitValid.
- DigitReady  output  1  converter will consume Digit this cycle.
- Busy  output  1  conversion in progress (state ACCEPT).
- Done  output  1  one-cycle pulse: Value is final.
- Value  output  WIDTH  running/final binary result.
- Overflow  output  1  sticky: result exceeded 8191 and was saturated.
- Error  output  1  sticky: a digit >9 was presented.

Behaviour:
- Reset (Reset_n=0 at edge): state IDLE; Value=0, Done=0, Busy=0, Overflow=0, Error=0, digit count=0. Reset mid-conversion aborts with no Done.
- States: IDLE, ACCEPT, DONE.
- IDLE:
  - DigitReady=0.
  - Start=1 -> ACCEPT next cycle, with Value=0, count=0, Overflow=0, Error=0.
- ACCEPT:
  - Busy=1. DigitReady = ~Start (combinational).
  - Transfer occurs when DigitValid & DigitReady.
- Legal digit (0..9) transfer:
  - next Value = Value*10 + Digit, computed as (Value<<3)+(Value<<1)+Digit in at least WIDTH+4 bits.
  - If the sum > 8191: Value=8191, Overflow=1. Once Overflow=1, Value holds 8191 for the rest of the conversion.
  - count increments.
- Illegal digit (10..15) transfer:
  - Digit is consumed; Value and count unchanged; Error=1.
  - DigitLast on an illegal digit still ends the conversion.
- Conversion end: after a transfer with DigitLast=1, or when count reaches NUM_DIGITS -> DONE.
- DONE (exactly one cycle):
  - Done=1, Busy=0, DigitReady=0, then IDLE.
  - Start during DONE -> ACCEPT with cleared state; Done still pulses.
- Start during ACCEPT: restarts. Value=0, count=0, flags cleared, stay ACCEPT; no Done. The concurrent digit is not consumed (DigitReady=0).
- Latency:
  - Value reflects each accepted digit on the next cycle.
  - Done asserts the cycle after the final transfer, with Value already final.
- Value, Overflow, Error hold after DONE until the next Start or reset.
- DigitValid in IDLE/DONE is ignored (no transfer).
- Zero-digit case: Start, then DigitLast with an illegal digit -> Done with Value=0, Error=1.

Test Plan:
- Reset_n=0 for 2 cycles with DigitValid=1, Start=1 -> all outputs 0, DigitReady=0; first cycle after release still IDLE.
- Start, then digits 4,0,9,5 back-to-back with DigitValid=1 -> DigitReady high 4 cycles; Value 4,40,409,4095; Done pulses 1 cycle after digit 4 with Value=4095, Overflow=0, Error=0.
- Start, then digits 9,9,9,9 -> Value 9,99,999, then 8191 with Overflow=1; Done pulses; Value stays 8191 until next Start.
- Start, then digits 1,2 with DigitLast=1 on the 2 -> Done one cycle after the 2, Value=12; a third digit offered afterwards is not consumed (DigitReady=0).
- Start, then 7, 0xB, 3, 1, 0 with gaps of DigitValid=0 -> 0xB consumed, Error=1, count not incremented; Done after the fifth transfer, Value=7310.
- Start, then 5, 6; Start and DigitValid(8) in the same cycle -> DigitReady=0 that cycle, Value=0, no Done; then 8 -> Value=8. Repeat with Reset_n=0 mid-conversion -> IDLE, Value=0, no Done.
